// File: rtl/imem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory arbiter: the ownership state
// enum and the default sizing constants used by imem_arbiter.
// ---------------------------------------------------------------------------
package imem_pkg;

   // Defaults for the arbiter parameters
   localparam int LOAD_BURST_MAX_DEF = 4;
   localparam int AW_DEF             = 32;
   localparam int DW_DEF             = 32;

   // Owner of the most recent transfer (IDLE when there was none)
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FETCH = 2'd2
   } state_t;

endpackage

// File: rtl/imem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_arbiter
// Shares one single-port instruction memory between a fetch port (read only)
// and a loader port (write only). The loader has priority. A fetch that is
// kept waiting is served after LOAD_BURST_MAX consecutive loader transfers.
// Fetch data is registered and comes back one cycle after the transfer edge.
//
// Ports
//   clk, reset               clock, asynchronous active-high reset
//   f_req/f_addr/f_gnt       fetch handshake (transfer = f_req && f_gnt)
//   f_valid/f_data/f_err     one-cycle registered fetch response
//   l_req/l_addr/l_wdata     loader write handshake
//   l_gnt                    loader grant (transfer = l_req && l_gnt)
//   l_err                    pulse the cycle after a misaligned loader write
//   memWrite/address/Data_in InstMem write enable, address, write data
//   Data_out                 InstMem combinational read data
// ---------------------------------------------------------------------------
module imem_arbiter
   import imem_pkg::*;
#(
   parameter int LOAD_BURST_MAX = LOAD_BURST_MAX_DEF,
   parameter int AW             = AW_DEF,
   parameter int DW             = DW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   output logic          f_gnt,
   output logic          f_valid,
   output logic [DW-1:0] f_data,
   output logic          f_err,
   input  logic          l_req,
   input  logic [AW-1:0] l_addr,
   input  logic [DW-1:0] l_wdata,
   output logic          l_gnt,
   output logic          l_err,
   output logic          memWrite,
   output logic [AW-1:0] address,
   output logic [DW-1:0] Data_in,
   input  logic [DW-1:0] Data_out
);

   localparam int            CW          = $clog2(LOAD_BURST_MAX) + 1;
   localparam logic [CW-1:0] BURST_LIMIT = CW'(LOAD_BURST_MAX);
   localparam logic [CW-1:0] BURST_ONE   = CW'(1);

   state_t        r_state;
   logic [CW-1:0] r_burstCnt;
   logic [AW-1:0] r_addrHold;
   logic [DW-1:0] r_dataHold;
   logic          r_fValid;
   logic [DW-1:0] r_fData;
   logic          r_fErr;
   logic          r_lErr;

   logic w_burstFull;
   logic w_lXfer;
   logic w_fXfer;
   logic w_lAligned;
   logic w_fAligned;

   // Grants depend only on requests and registered state. They are forced low
   // during reset so nothing transfers or writes while reset is asserted.
   always_comb begin
      w_burstFull = (r_burstCnt == BURST_LIMIT);
      w_lXfer     = !reset && l_req && !(w_burstFull && f_req);
      w_fXfer     = !reset && f_req && !w_lXfer;
      w_lAligned  = (l_addr[1:0] == 2'b00);
      w_fAligned  = (f_addr[1:0] == 2'b00);
   end

   assign l_gnt = w_lXfer;
   assign f_gnt = w_fXfer;

   // Misaligned loader writes are dropped. With no transfer, the memory
   // address and write data hold their last driven values to avoid toggling.
   always_comb begin
      memWrite = w_lXfer && w_lAligned;
      address  = r_addrHold;
      Data_in  = r_dataHold;
      if (w_lXfer) begin
         address = l_addr;
         Data_in = l_wdata;
      end else if (w_fXfer) begin
         address = f_addr;
      end
   end

   assign f_valid = r_fValid;
   assign f_data  = r_fData;
   assign f_err   = r_fErr;
   assign l_err   = r_lErr;

   // Ownership state, burst counter, held bus values and fetch/loader responses.
   // The burst counter only runs while a fetch is waiting behind the loader.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_burstCnt <= '0;
         r_addrHold <= '0;
         r_dataHold <= '0;
         r_fValid   <= 1'b0;
         r_fData    <= '0;
         r_fErr     <= 1'b0;
         r_lErr     <= 1'b0;
      end else begin
         r_fValid <= w_fXfer;
         r_fErr   <= w_fXfer && !w_fAligned;
         r_lErr   <= w_lXfer && !w_lAligned;
         r_addrHold <= address;
         r_dataHold <= Data_in;

         if (w_lXfer)
            r_state <= LOAD;
         else if (w_fXfer)
            r_state <= FETCH;
         else
            r_state <= IDLE;

         if (w_fXfer)
            r_fData <= Data_out;

         if (w_fXfer || !f_req)
            r_burstCnt <= '0;
         else if (w_lXfer && !w_burstFull)
            r_burstCnt <= r_burstCnt + BURST_ONE;
      end
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_arbiter
// Directed bench for imem_arbiter with a small word-addressed instruction
// memory model hung off the memWrite/address/Data_in/Data_out bus.
// ---------------------------------------------------------------------------
module tb_imem_arbiter;
   import imem_pkg::*;

   logic        clk;
   logic        reset;
   logic        f_req;
   logic [31:0] f_addr;
   logic        f_gnt;
   logic        f_valid;
   logic [31:0] f_data;
   logic        f_err;
   logic        l_req;
   logic [31:0] l_addr;
   logic [31:0] l_wdata;
   logic        l_gnt;
   logic        l_err;
   logic        memWrite;
   logic [31:0] address;
   logic [31:0] Data_in;
   logic [31:0] Data_out;

   logic        memInit;
   logic [31:0] mem [0:255];

   int checks = 0;
   int errors = 0;

   imem_arbiter #(.LOAD_BURST_MAX(4), .AW(32), .DW(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .f_req   (f_req),
      .f_addr  (f_addr),
      .f_gnt   (f_gnt),
      .f_valid (f_valid),
      .f_data  (f_data),
      .f_err   (f_err),
      .l_req   (l_req),
      .l_addr  (l_addr),
      .l_wdata (l_wdata),
      .l_gnt   (l_gnt),
      .l_err   (l_err),
      .memWrite(memWrite),
      .address (address),
      .Data_in (Data_in),
      .Data_out(Data_out)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instruction memory model: preload word i with 0xC0DE0000 + i, then
   // accept aligned writes from the arbiter; reads are combinational.
   always @(posedge clk) begin
      if (memInit) begin
         for (int i = 0; i < 256; i++)
            mem[i] <= 32'hC0DE0000 | i;
      end else if (memWrite) begin
         mem[address[9:2]] <= Data_in;
      end
   end

   assign Data_out = mem[address[9:2]];

   task automatic test_reset();
      reset   = 1'b1;
      memInit = 1'b1;
      f_req   = 1'b1;
      f_addr  = 32'h0000_0010;
      l_req   = 1'b1;
      l_addr  = 32'h0000_0040;
      l_wdata = 32'hFFFF_FFFF;
      repeat (2) @(negedge clk);
      memInit = 1'b0;
      #1;
      checks++;
      if (l_gnt !== 1'b0 || f_gnt !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_gnt: l_gnt=%b f_gnt=%b expected 0 0", l_gnt, f_gnt);
      end
      checks++;
      if (memWrite !== 1'b0 || address !== 32'h0 || Data_in !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_bus: memWrite=%b address=%h Data_in=%h expected 0 0 0",
                  memWrite, address, Data_in);
      end
      checks++;
      if (f_valid !== 1'b0 || f_data !== 32'h0 || f_err !== 1'b0 || l_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_resp: f_valid=%b f_data=%h f_err=%b l_err=%b expected all 0",
                  f_valid, f_data, f_err, l_err);
      end
      checks++;
      if (dut.r_state !== IDLE) begin
         errors++;
         $display("[TB] FAIL reset_state: got %0d expected %0d", dut.r_state, IDLE);
      end
      f_req = 1'b0;
      l_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Three back-to-back fetches of words 0, 1, 2
   task automatic test_fetch_burst();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i > 0) begin
            checks++;
            if (f_valid !== 1'b1 || f_data !== (32'hC0DE0000 | (i - 1))) begin
               errors++;
               $display("[TB] FAIL fetch_burst_data%0d: f_valid=%b f_data=%h expected 1 %h",
                        i - 1, f_valid, f_data, 32'hC0DE0000 | (i - 1));
            end
         end
         if (i < 3) begin
            f_req  = 1'b1;
            f_addr = 32'(i * 4);
            #1;
            checks++;
            if (f_gnt !== 1'b1 || l_gnt !== 1'b0 || address !== 32'(i * 4)) begin
               errors++;
               $display("[TB] FAIL fetch_burst_gnt%0d: f_gnt=%b l_gnt=%b address=%h expected 1 0 %h",
                        i, f_gnt, l_gnt, address, i * 4);
            end
         end else begin
            f_req = 1'b0;
         end
      end
      #1;
      checks++;
      if (address !== 32'h8 || memWrite !== 1'b0 || f_gnt !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idle_hold: address=%h memWrite=%b f_gnt=%b expected 8 0 0",
                  address, memWrite, f_gnt);
      end
      @(negedge clk);
      checks++;
      if (f_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL fetch_burst_end: f_valid=%b expected 0", f_valid);
      end
   endtask

   // Loader write immediately followed by a fetch of the same word
   task automatic test_write_then_read();
      @(negedge clk);
      l_req   = 1'b1;
      l_addr  = 32'h4;
      l_wdata = 32'h1234_5678;
      #1;
      checks++;
      if (l_gnt !== 1'b1 || memWrite !== 1'b1 || address !== 32'h4 || Data_in !== 32'h1234_5678) begin
         errors++;
         $display("[TB] FAIL load_write: l_gnt=%b memWrite=%b address=%h Data_in=%h expected 1 1 4 12345678",
                  l_gnt, memWrite, address, Data_in);
      end
      @(negedge clk);
      l_req  = 1'b0;
      f_req  = 1'b1;
      f_addr = 32'h4;
      #1;
      checks++;
      if (f_gnt !== 1'b1 || memWrite !== 1'b0) begin
         errors++;
         $display("[TB] FAIL raw_gnt: f_gnt=%b memWrite=%b expected 1 0", f_gnt, memWrite);
      end
      @(negedge clk);
      f_req = 1'b0;
      checks++;
      if (f_valid !== 1'b1 || f_data !== 32'h1234_5678 || f_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL raw_data: f_valid=%b f_data=%h f_err=%b expected 1 12345678 0",
                  f_valid, f_data, f_err);
      end
      #1;
      checks++;
      if (Data_in !== 32'h1234_5678 || address !== 32'h4) begin
         errors++;
         $display("[TB] FAIL idle_data_hold: Data_in=%h address=%h expected 12345678 4",
                  Data_in, address);
      end
   endtask

   // Both ports requesting for 10 cycles: L,L,L,L,F,L,L,L,L,F
   task automatic test_arbitration();
      logic expF;
      @(negedge clk);
      f_req   = 1'b1;
      f_addr  = 32'h10;
      l_req   = 1'b1;
      l_addr  = 32'h20;
      l_wdata = 32'hA5A5_0000;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         expF = (i == 4) || (i == 9);
         checks++;
         if (f_gnt !== expF || l_gnt !== !expF) begin
            errors++;
            $display("[TB] FAIL arb_cycle%0d: f_gnt=%b l_gnt=%b expected %b %b",
                     i, f_gnt, l_gnt, expF, !expF);
         end
         if (i == 5) begin
            checks++;
            if (f_valid !== 1'b1 || f_data !== 32'hC0DE0004) begin
               errors++;
               $display("[TB] FAIL arb_fetch_data: f_valid=%b f_data=%h expected 1 c0de0004",
                        f_valid, f_data);
            end
         end
      end
      @(negedge clk);
      f_req = 1'b0;
      l_req = 1'b0;
   endtask

   // Misaligned loader write is dropped and flagged
   task automatic test_misaligned_write();
      @(negedge clk);
      l_req   = 1'b1;
      l_addr  = 32'h6;
      l_wdata = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (l_gnt !== 1'b1 || memWrite !== 1'b0 || address !== 32'h6) begin
         errors++;
         $display("[TB] FAIL misaligned_wr: l_gnt=%b memWrite=%b address=%h expected 1 0 6",
                  l_gnt, memWrite, address);
      end
      @(negedge clk);
      l_req = 1'b0;
      checks++;
      if (l_err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL l_err_pulse: l_err=%b expected 1", l_err);
      end
      f_req  = 1'b1;
      f_addr = 32'h4;
      @(negedge clk);
      f_req = 1'b0;
      checks++;
      if (l_err !== 1'b0 || f_valid !== 1'b1 || f_data !== 32'h1234_5678 || f_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL misaligned_unchanged: l_err=%b f_valid=%b f_data=%h f_err=%b expected 0 1 12345678 0",
                  l_err, f_valid, f_data, f_err);
      end
   endtask

   // Misaligned fetch returns the containing word with f_err set
   task automatic test_misaligned_fetch();
      @(negedge clk);
      f_req  = 1'b1;
      f_addr = 32'h2;
      @(negedge clk);
      f_req = 1'b0;
      checks++;
      if (f_valid !== 1'b1 || f_err !== 1'b1 || f_data !== 32'hC0DE0000) begin
         errors++;
         $display("[TB] FAIL misaligned_fetch: f_valid=%b f_err=%b f_data=%h expected 1 1 c0de0000",
                  f_valid, f_err, f_data);
      end
   endtask

   // Reset landing on a fetch transfer, then on a loader transfer
   task automatic test_reset_mid_transfer();
      @(negedge clk);
      f_req  = 1'b1;
      f_addr = 32'h8;
      #1;
      checks++;
      if (f_gnt !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_fetch_gnt: f_gnt=%b expected 1", f_gnt);
      end
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (f_valid !== 1'b0 || f_gnt !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_fetch_abort: f_valid=%b f_gnt=%b expected 0 0", f_valid, f_gnt);
      end
      @(negedge clk);
      f_req = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (f_valid !== 1'b0 || f_data !== 32'h0 || f_err !== 1'b0 || l_err !== 1'b0 ||
          address !== 32'h0 || Data_in !== 32'h0 || memWrite !== 1'b0 || dut.r_state !== IDLE) begin
         errors++;
         $display("[TB] FAIL reset_after: f_valid=%b f_data=%h f_err=%b l_err=%b address=%h Data_in=%h memWrite=%b state=%0d expected all 0",
                  f_valid, f_data, f_err, l_err, address, Data_in, memWrite, dut.r_state);
      end

      l_req   = 1'b1;
      l_addr  = 32'hC;
      l_wdata = 32'h55AA_55AA;
      #1;
      checks++;
      if (l_gnt !== 1'b1 || memWrite !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_load_gnt: l_gnt=%b memWrite=%b expected 1 1", l_gnt, memWrite);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (memWrite !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_load_wr: memWrite=%b expected 0", memWrite);
      end
      @(negedge clk);
      l_req = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (mem[3] !== 32'hC0DE0003 || l_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_load_abort: mem[3]=%h l_err=%b expected c0de0003 0", mem[3], l_err);
      end
   endtask

   initial begin
      reset   = 1'b1;
      memInit = 1'b0;
      f_req   = 1'b0;
      f_addr  = '0;
      l_req   = 1'b0;
      l_addr  = '0;
      l_wdata = '0;
      test_reset();
      test_fetch_burst();
      test_write_then_read();
      test_arbitration();
      test_misaligned_write();
      test_misaligned_fetch();
      test_reset_mid_transfer();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter LOAD_BURST_MAX, default 4: max consecutive loader transfers while a fetch is waiting.
REQ-002 Parameter AW, default 32: address width.
REQ-003 Parameter DW, default 32: data width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 f_req  input  1  fetch request; held with f_addr until transfer.
REQ-007 f_addr  input  AW  fetch byte address.
REQ-008 f_gnt  output  1  fetch grant; transfer when f_req && f_gnt at rising edge.
REQ-009 f_valid  output  1  one-cycle pulse: f_data/f_err valid.
REQ-010 f_data  output  DW  registered instruction word.
REQ-011 f_err  output  1  registered misaligned-fetch flag, qualified by f_valid.
REQ-012 l_req  input  1  loader write request; held with l_addr/l_wdata until transfer.
REQ-013 l_addr  input  AW  loader byte address.
REQ-014 l_wdata  input  DW  loader write data.
REQ-015 l_gnt  output  1  loader grant; transfer when l_req && l_gnt at rising edge.
REQ-016 l_err  output  1  one-cycle pulse, cycle after a misaligned loader transfer.
REQ-017 memWrite  output  1  InstMem write enable.
REQ-018 address  output  AW  InstMem address.
REQ-019 Data_in  output  DW  InstMem write data.
REQ-020 Data_out  input  DW  InstMem combinational read data.

Function
REQ-021 FSM states IDLE, LOAD, FETCH; state = owner of last transfer; IDLE when the previous cycle had no transfer.
REQ-022 At most one of f_gnt/l_gnt high per cycle; gnt is combinational from req and registered state, never from Data_out.
REQ-023 Default priority loader over fetch: l_req=1 -> l_gnt=1, unless burst_cnt == LOAD_BURST_MAX and f_req=1, in which case f_gnt=1.
REQ-024 burst_cnt (width clog2(LOAD_BURST_MAX)+1) increments on each loader transfer while f_req=1, saturates at LOAD_BURST_MAX, clears on any fetch transfer or any cycle with f_req=0.
REQ-025 Only f_req=1: f_gnt=1 every cycle; back-to-back fetches at one per cycle.
REQ-026 Loader transfer cycle: memWrite = (l_addr[1:0]==0), address=l_addr, Data_in=l_wdata.
REQ-027 Misaligned loader transfer: memWrite=0, write dropped, l_err=1 next cycle.
REQ-028 Fetch transfer cycle: memWrite=0, address=f_addr; Data_out captured into f_data at that edge; f_valid=1 and f_err=(f_addr[1:0]!=0) next cycle for one cycle.
REQ-029 No transfer: memWrite=0, address and Data_in hold their last driven values (no toggling).
REQ-030 Fetch read latency exactly 1 cycle from transfer edge to f_valid; no data lost at full rate.
REQ-031 Simultaneous f_req and l_req with burst_cnt < LOAD_BURST_MAX: loader served, fetch stalls with f_gnt=0.
REQ-032 Fetch read of an address written in the immediately preceding cycle returns the new data.

Reset
REQ-033 While reset=1: state=IDLE, burst_cnt=0, f_gnt=0, l_gnt=0, memWrite=0, f_valid=0, f_err=0, l_err=0, f_data=0, address=0, Data_in=0.
REQ-034 Reset asserted mid-transfer aborts it: no write commits and no f_valid follows deassertion.

Structure
REQ-035 Package imem_pkg holds the state enum (IDLE/LOAD/FETCH), default LOAD_BURST_MAX, AW/DW constants.
REQ-036 No sub-module required; InstMem is instantiated alongside imem_arbiter in the top level, not inside it.

Verification
REQ-037 Fetch only, f_addr 0x0,0x4,0x8 back-to-back -> f_gnt high 3 cycles, f_valid 3 consecutive cycles with mem[0],mem[1],mem[2].
REQ-038 Loader writes 0x12345678 to 0x4, then fetch 0x4 next cycle -> f_data=0x12345678, f_err=0.
REQ-039 f_req and l_req held high 10 cycles, LOAD_BURST_MAX=4 -> grant pattern L,L,L,L,F,L,L,L,L,F.
REQ-040 Loader writes 0xDEADBEEF to 0x6 -> memWrite stays 0, l_err pulses once, fetch 0x4 unchanged.
REQ-041 reset pulsed during a fetch transfer cycle -> no f_valid afterwards, all outputs 0, state IDLE.
REQ-042 Fetch 0x2 -> f_valid with f_err=1.
